// File: rtl/decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | decode_pkg : opcode constants and format class shared by the decode stage  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package decode_pkg;

  localparam logic [6:0] c_op_op       = 7'b0110011;
  localparam logic [6:0] c_op_imm      = 7'b0010011;
  localparam logic [6:0] c_op_load     = 7'b0000011;
  localparam logic [6:0] c_op_jalr     = 7'b1100111;
  localparam logic [6:0] c_op_system   = 7'b1110011;
  localparam logic [6:0] c_op_misc_mem = 7'b0001111;
  localparam logic [6:0] c_op_store    = 7'b0100011;
  localparam logic [6:0] c_op_branch   = 7'b1100011;
  localparam logic [6:0] c_op_lui      = 7'b0110111;
  localparam logic [6:0] c_op_auipc    = 7'b0010111;
  localparam logic [6:0] c_op_jal      = 7'b1101111;
  localparam logic [6:0] c_op_imm_32   = 7'b0011011;
  localparam logic [6:0] c_op_op_32    = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  // The decoded entry depends on XLEN/PC_W, so its struct typedef lives in the stage.
  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_extract.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_extract : combinational format classification and immediate extraction |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module imm_extract
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam bit c_is_rv64 = (XLEN == 64);

  fmt_e               w_fmt;
  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [20:0] w_imm_j;
  logic signed [31:0] w_imm_u;

  assign w_imm_i = instr[31:20];
  assign w_imm_s = {instr[31:25], instr[11:7]};
  assign w_imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign w_imm_u = {instr[31:12], 12'b0};

  always_comb begin
    w_fmt = FMT_NONE;
    if (instr[1:0] == 2'b11) begin
      case (opcode_of(instr))
        c_op_op:      w_fmt = FMT_R;
        c_op_imm, c_op_load, c_op_jalr, c_op_system, c_op_misc_mem:
                      w_fmt = FMT_I;
        c_op_store:   w_fmt = FMT_S;
        c_op_branch:  w_fmt = FMT_B;
        c_op_lui, c_op_auipc:
                      w_fmt = FMT_U;
        c_op_jal:     w_fmt = FMT_J;
        c_op_imm_32:  if (c_is_rv64) w_fmt = FMT_I;
        c_op_op_32:   if (c_is_rv64) w_fmt = FMT_R;
        default:      w_fmt = FMT_NONE;
      endcase
    end
  end

  // Size casts of signed operands sign-extend to XLEN.
  always_comb begin
    imm = '0;
    case (w_fmt)
      FMT_I:   imm = XLEN'(w_imm_i);
      FMT_S:   imm = XLEN'(w_imm_s);
      FMT_B:   imm = XLEN'(w_imm_b);
      FMT_J:   imm = XLEN'(w_imm_j);
      FMT_U:   imm = XLEN'(w_imm_u);
      default: imm = '0;
    endcase
  end

  assign fmt     = w_fmt;
  assign illegal = (w_fmt == FMT_NONE);

endmodule
`default_nettype wire

// File: rtl/instr_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_decode_stage : registered RV32I/RV64I decode with 2-entry skid buffer |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    fmt_e            fmt;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam entry_t c_entry_rst = '{
    imm: '0, rd: '0, rs1: '0, rs2: '0, funct3: '0, funct7: '0,
    fmt: FMT_NONE, illegal: 1'b0, pc: '0
  };

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  entry_t          w_dec;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_in_ready;
  entry_t r_main;
  entry_t r_skid;
  logic   w_in_xfer;
  logic   w_out_xfer;
  logic   w_load_main_in;
  logic   w_load_main_skid;
  logic   w_load_skid;

  imm_extract #(
    .XLEN (XLEN)
  ) u_imm_extract (
    .instr   (in_instr),
    .imm     (w_imm),
    .fmt     (w_fmt),
    .illegal (w_illegal)
  );

  assign w_dec = '{
    imm:     w_imm,
    rd:      in_instr[11:7],
    rs1:     in_instr[19:15],
    rs2:     in_instr[24:20],
    funct3:  in_instr[14:12],
    funct7:  in_instr[31:25],
    fmt:     fmt_e'(w_fmt),
    illegal: w_illegal,
    pc:      in_pc
  };

  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = (r_state != ST_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt    = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_main_in = 1'b1;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_xfer) begin
            w_state_nxt      = ST_ONE;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main <= c_entry_rst;
      r_skid <= c_entry_rst;
    end else begin
      if (w_load_main_in) begin
        r_main <= w_dec;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_imm     = r_main.imm;
  assign out_rd      = r_main.rd;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_funct3  = r_main.funct3;
  assign out_funct7  = r_main.funct7;
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instr_decode_stage : directed bench for XLEN=32 and XLEN=64 instances   |
// | Revision              : 1.0                                                |
// +----------------------------------------------------------------------------+
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32, pc32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32, fmt32;
  logic [6:0]  f7_32;

  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [31:0] pc64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64, fmt64;
  logic [6:0]  f7_64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_decode_stage #(.XLEN(32), .PC_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_fmt(fmt32), .out_illegal(ill32),
    .out_pc(pc32)
  );

  instr_decode_stage #(.XLEN(64), .PC_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(f3_64), .out_funct7(f7_64), .out_fmt(fmt64), .out_illegal(ill64),
    .out_pc(pc64)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_pc     = pc;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ov32"},  out_valid32, 0);
    check_eq({tag, "_ir32"},  in_ready32,  1);
    check_eq({tag, "_imm32"}, imm32,       0);
    check_eq({tag, "_fmt32"}, fmt32,       7);
    check_eq({tag, "_ill32"}, ill32,       0);
    check_eq({tag, "_pc32"},  pc32,        0);
    check_eq({tag, "_flds32"}, {rd32, rs1_32, rs2_32, f3_32, f7_32}, 0);
    check_eq({tag, "_ov64"},  out_valid64, 0);
    check_eq({tag, "_ir64"},  in_ready64,  1);
    check_eq({tag, "_imm64"}, imm64,       0);
    check_eq({tag, "_fmt64"}, fmt64,       7);
    check_eq({tag, "_flds64"}, {ill64, pc64, rd64, rs1_64, rs2_64, f3_64, f7_64}, 0);
  endtask

  initial begin
    int idx_in, idx_out;
    logic fire_in, fire_out;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    check_reset("rst");
    rst = 1'b0;

    // Single-instruction decode, one new entry per cycle.
    send(32'hFFF00093, 32'h1000);
    check_eq("addi_ov",   out_valid32, 1);
    check_eq("addi_imm",  imm32, 64'h0000_0000_FFFF_FFFF);
    check_eq("addi_rd",   rd32, 1);
    check_eq("addi_rs1",  rs1_32, 0);
    check_eq("addi_fmt",  fmt32, 1);
    check_eq("addi_ill",  ill32, 0);
    check_eq("addi_pc",   pc32, 32'h1000);
    check_eq("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    send(32'h00000463, 32'h1004);
    check_eq("beq_imm", imm32, 8);
    check_eq("beq_fmt", fmt32, 3);
    check_eq("beq_pc",  pc32, 32'h1004);

    send(32'hFFDFF06F, 32'h1008);
    check_eq("jal_imm", imm32, 64'h0000_0000_FFFF_FFFC);
    check_eq("jal_fmt", fmt32, 5);
    check_eq("jal_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFC);

    send(32'h123452B7, 32'h100C);
    check_eq("lui_imm", imm32, 64'h0000_0000_1234_5000);
    check_eq("lui_rd",  rd32, 5);
    check_eq("lui_fmt", fmt32, 4);

    send(32'h0020A423, 32'h1010);
    check_eq("sw_imm", imm32, 8);
    check_eq("sw_fmt", fmt32, 2);
    check_eq("sw_fields", {rs1_32, rs2_32, f3_32}, {5'd1, 5'd2, 3'd2});

    send(32'h402081B3, 32'h1014);
    check_eq("sub_imm", imm32, 0);
    check_eq("sub_fmt", fmt32, 0);
    check_eq("sub_fields", {rd32, f7_32}, {5'd3, 7'h20});

    send(32'h00000000, 32'h1018);
    check_eq("zero_ill", ill32, 1);
    check_eq("zero_fmt", fmt32, 7);
    check_eq("zero_imm", imm32, 0);

    send(32'h0000007F, 32'h101C);
    check_eq("op7f_ill", ill32, 1);
    check_eq("op7f_fmt", fmt32, 7);
    check_eq("op7f_imm", imm32, 0);

    send(32'hFFF00090, 32'h1020);
    check_eq("lowbits_ill", ill32, 1);
    check_eq("lowbits_imm", imm32, 0);
    check_eq("lowbits_rd",  rd32, 1);

    send(32'h0010009B, 32'h1024);
    check_eq("addiw32_ill", ill32, 1);
    check_eq("addiw32_fmt", fmt32, 7);
    check_eq("addiw64_fmt", fmt64, 1);
    check_eq("addiw64_imm", imm64, 1);
    check_eq("addiw64_ill", ill64, 0);

    send(32'h800002B7, 32'h1028);
    check_eq("lui64_imm", imm64, 64'hFFFF_FFFF_8000_0000);
    check_eq("lui32_imm", imm32, 64'h0000_0000_8000_0000);

    send(32'h0000003B, 32'h102C);
    check_eq("addw64_fmt", fmt64, 0);
    check_eq("addw32_ill", ill32, 1);

    step();
    check_eq("drain_ov", out_valid32, 0);

    // Backpressure: five addi's with imm 1..5, stalled then released.
    out_ready = 1'b0;
    idx_in = 0; idx_out = 0;
    in_valid = 1'b1;
    in_instr = 32'h00100093;
    in_pc    = 32'h200;
    for (int cyc = 0; cyc < 40 && idx_out < 5; cyc++) begin
      if (cyc == 3) begin
        check_eq("bp_accepted", idx_in, 2);
        check_eq("bp_in_ready", in_ready32, 0);
        check_eq("bp_hold_imm", imm32, 1);
        out_ready = 1'b1;
      end
      fire_in  = in_valid & in_ready32;
      fire_out = out_valid32 & out_ready;
      if (fire_out) begin
        check_eq($sformatf("bp_imm%0d", idx_out), imm32, 64'(idx_out + 1));
        check_eq($sformatf("bp_pc%0d", idx_out), pc32, 64'(32'h200 + 4 * idx_out));
        check_eq($sformatf("bp_imm64_%0d", idx_out), imm64, 64'(idx_out + 1));
        idx_out++;
      end
      step();
      if (fire_in) begin
        idx_in++;
        if (idx_in < 5) begin
          in_instr = 32'h00100093 + (idx_in << 20);
          in_pc    = 32'h200 + 4 * idx_in;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check_eq("bp_out_count", idx_out, 5);
    check_eq("bp_in_count", idx_in, 5);
    step();
    check_eq("bp_empty", out_valid32, 0);

    // Flush while FULL with an input pending.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h01100093; in_pc = 32'h300; step();
    in_instr = 32'h02200093; in_pc = 32'h304; step();
    check_eq("full_in_ready", in_ready32, 0);
    in_instr = 32'h7FF00093; in_pc = 32'h308; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_full_ov", out_valid32, 0);
    check_eq("flush_full_ir", in_ready32, 1);
    step();
    check_eq("flush_full_stay", out_valid32, 0);

    // Flush in ONE while an input transfer is offered: the input is dropped.
    in_valid = 1'b1; in_instr = 32'h01100093; step();
    in_instr = 32'h7FF00093; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("flush_one_ov", out_valid32, 0);
    step();
    check_eq("flush_one_stay", out_valid32, 0);
    send(32'h05500093, 32'h400);
    check_eq("post_flush_imm", imm32, 32'h55);
    check_eq("post_flush_pc", pc32, 32'h400);
    step();
    check_eq("post_flush_drain", out_valid32, 0);

    // Reset mid-stream from FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFDFF06F; in_pc = 32'h500; step();
    in_instr = 32'h123452B7; in_pc = 32'h504; step();
    rst = 1'b1; step();
    check_reset("midrst");
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_eq("post_rst_ov", out_valid32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
